// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Brief    : Moore detector for a programmable 1..PAT_W-bit serial pattern,
//            with overlap/non-overlap modes and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x1,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             z1,
    output logic [LEN_W-1:0] state,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam logic [LEN_W-1:0] c_pat_w = LEN_W'(PAT_W);

    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [PAT_W-1:0] r_hist;      // bit 0 is the most recently accepted bit
    logic [LEN_W-1:0] r_depth;
    logic [LEN_W-1:0] r_state;
    logic             r_z1;
    logic [CNT_W-1:0] r_count;

    logic [PAT_W-1:0] w_hist_nx;
    logic [LEN_W-1:0] w_depth_nx;
    logic [LEN_W-1:0] w_next_state;
    logic [LEN_W-1:0] w_len_clamped;
    logic             w_match;
    logic             w_sat;

    assign w_hist_nx  = {r_hist[PAT_W-2:0], x1};
    assign w_depth_nx = (r_depth == c_pat_w) ? c_pat_w : r_depth + LEN_W'(1);

    always_comb begin
        w_len_clamped = cfg_len;
        if (cfg_len == '0)
            w_len_clamped = LEN_W'(1);
        else if (cfg_len > c_pat_w)
            w_len_clamped = c_pat_w;
    end

    // Ascending scan so the longest matching prefix wins.
    always_comb begin
        logic w_eq;
        w_next_state = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            w_eq = (LEN_W'(k) <= r_len) && (LEN_W'(k) <= w_depth_nx);
            for (int i = 0; i < k; i++) begin
                if (w_hist_nx[k-1-i] != r_pattern[i])
                    w_eq = 1'b0;
            end
            if (w_eq)
                w_next_state = LEN_W'(k);
        end
    end

    assign w_match = x_valid && !cfg_load && (w_next_state == r_len);
    assign w_sat   = &r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= c_pat_w;
            r_overlap <= 1'b0;
            r_hist    <= '0;
            r_depth   <= '0;
            r_state   <= '0;
            r_z1      <= 1'b0;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
            r_hist    <= '0;
            r_depth   <= '0;
            r_state   <= '0;
            r_z1      <= 1'b0;
        end else if (x_valid) begin
            r_state <= w_next_state;
            r_z1    <= w_match;
            if (w_match && !r_overlap) begin
                r_hist  <= '0;
                r_depth <= '0;
            end else begin
                r_hist  <= w_hist_nx;
                r_depth <= w_depth_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (cnt_clr)
            r_count <= w_match ? CNT_W'(1) : '0;
        else if (w_match && !w_sat)
            r_count <= r_count + CNT_W'(1);
    end

    assign z1          = r_z1;
    assign state       = r_state;
    assign match_count = r_count;
    assign count_sat   = w_sat;

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Moore sequence detector, the successor to the team's fixed five-state `x1` detector. It matches a runtime-programmable serial pattern of 1..`PAT_W` bits, with selectable overlapping or non-overlapping detection. It adds a bit-valid qualifier, a saturating match counter and a fully registered match output with no clock gating. It sits between the `ui_in` pin decode and the `uo_out` status mapping in the TinyTapeout top.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits (≥2).
- `CNT_W`, default 8: match counter width.
- `LEN_W`, default `$clog2(PAT_W+1)`: width of length and state fields.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `x1`  in  1  serial data bit.
- `x_valid`  in  1  `x1` is accepted on an edge where this is high.
- `cfg_load`  in  1  latch `cfg_*`, clear detection progress.
- `cfg_pattern`  in  `PAT_W`  pattern; bit 0 is the first bit received.
- `cfg_len`  in  `LEN_W`  pattern length.
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `cnt_clr`  in  1  synchronous clear of `match_count`.
- `z1`  out  1  Moore match output; high while `state == len`.
- `state`  out  `LEN_W`  current matched-prefix length (0..len).
- `match_count`  out  `CNT_W`  number of matches, saturating.
- `count_sat`  out  1  high when `match_count` is all ones.

## Operation
- Registers:
  - pattern, len, overlap configuration;
  - history shift register of the last `PAT_W` accepted bits, plus a valid-depth count (bits since last clear, capped at `PAT_W`);
  - `state`;
  - `match_count`.
- Reset (`rst=1`):
  - pattern=0, len=`PAT_W`, overlap=0;
  - history and depth cleared; `state=0`, `z1=0`;
  - `match_count=0`, `count_sat=0`.
  - `rst` overrides every other input.
- Length clamp at `cfg_load`:
  - `cfg_len=0` is stored as 1;
  - `cfg_len>PAT_W` is stored as `PAT_W`.
- `cfg_load=1`:
  - store the config, clear history, depth and `state`;
  - `match_count` is untouched;
  - takes priority over `x_valid` in the same cycle, and that bit is discarded.
- Accepted bit (`x_valid=1`, no load/reset):
  - append `x1` to the history; depth = min(depth+1, `PAT_W`).
  - Next `state` = largest k, with 1 ≤ k ≤ min(len, depth), such that the last k history bits equal `pattern[0..k-1]` in arrival order; k=0 if none exists.
- Match: the next state equals len.
  - `match_count` increments by 1 unless it is saturated.
  - Overlap=1: history is retained, so the next bit may re-enter len (e.g. pattern `1111`).
  - Overlap=0: history and depth are cleared on the match edge. `state` still becomes len for that cycle, but subsequent bits are evaluated only against bits accepted after the match.
- `x_valid=0`: history, depth and `state` hold, and `z1` holds its value.
- `cnt_clr=1`: `match_count` becomes 0. If a match occurs on the same edge, `match_count` becomes 1.
- State decode:
  - `z1 = (state == len)`; `count_sat = &match_count`.
  - No combinational path from `x1`, `x_valid` or `clk` to `z1`.

## Timing
- Latency: the bit completing a pattern is sampled at edge N, and `z1` is high from edge N until the next accepted bit (at least 1 cycle).
- `state`, `z1` and `count_sat` change only on `clk` rising edges.
- A config change takes effect for the first accepted bit after the `cfg_load` edge; `z1=0` in the cycle after a load.
- Reset mid-stream: the partial match is lost and `z1` is low the cycle after `rst`.
- Back-to-back `x_valid` every cycle is fully supported; there are no stall or ready outputs.
- The next-state search is combinational over `PAT_W` comparators and must close at the project clock with `PAT_W=8`.

## Test plan
- Load pattern `1011`, len 4, overlap=1. Stream 1,0,1,1,0,1,1 → `z1` high after bits 4 and 7; `state` after bit 5 is 2; `match_count`=2.
- Same stream with overlap=0 → `z1` high only after bit 4; `state` after bit 7 is 1; `match_count`=1.
- Pattern `1111`, len 4. Six consecutive 1s → overlap=1 gives matches after bits 4, 5 and 6 (count 3); overlap=0 gives a match after bit 4 only, with `state`=2 after bit 6.
- `CNT_W=8`, pattern `1`, len 1, 300 ones → `match_count` stops at 255 with `count_sat=1`. Then `cnt_clr` together with a matching bit → count 1.
- Bubbles and priority:
  - `x_valid` low for 5 cycles mid-pattern → `state` and `z1` hold.
  - `cfg_load` together with `x_valid` → bit ignored, `state`=0.
  - `cfg_len`=0 → behaves as len 1; `cfg_len`=15 → behaves as len 8.
- `rst` asserted one bit before a completing bit → no match, `state=0`, and `z1`, `match_count` and `count_sat` all 0. After reset: pattern=0, len=`PAT_W`, so `PAT_W` zeros produce a match.
